// File: rtl/dmem_arb_pkg.sv
// Shared constants and the address check for the data-memory arbiter.
// Word-addressed 256 x 16-bit memory behind a byte-address interface.
package dmem_arb_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;
    localparam int MEM_WORDS  = 256;
    localparam int WIDX_LO    = 1;
    localparam int WIDX_HI    = 8;

    // Aligned word inside the 256-word window
    function automatic logic word_addr_ok(input logic [15:0] addr);
        return (addr[0] == 1'b0) && (addr[15:WIDX_HI+1] == '0);
    endfunction

endpackage

// File: rtl/dmem_req_check.sv
// Combinational validity check of one requester's byte address.
// Rejects misaligned and out-of-window addresses.
module dmem_req_check
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              ok
);

    assign ok = word_addr_ok(16'(addr));

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of the single-port data memory.
// Port A has priority until port B has waited MAX_WAIT cycles.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_err,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    logic [3:0] b_wait;
    logic       b_pri;
    logic       a_ok;
    logic       b_ok;
    logic       a_rd;
    logic       b_rd;

    dmem_req_check #(.ADDR_W(ADDR_W)) u_chk_a (
        .addr (a_addr),
        .ok   (a_ok)
    );

    dmem_req_check #(.ADDR_W(ADDR_W)) u_chk_b (
        .addr (b_addr),
        .ok   (b_ok)
    );

    assign b_pri = (b_wait == WAIT_MAX);
    assign a_rd  = a_gnt && a_ok && !a_we;
    assign b_rd  = b_gnt && b_ok && !b_we;

    // Grant selection and memory drive; nothing is granted in reset
    always_comb begin
        a_gnt     = 1'b0;
        b_gnt     = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        if (rst_n) begin
            b_gnt = b_req && (!a_req || b_pri);
            a_gnt = a_req && !b_gnt;
        end
        if (a_gnt && a_ok) begin
            mem_addr  = a_addr;
            mem_wdata = a_wdata;
            mem_we    = a_we;
            mem_re    = !a_we;
        end else if (b_gnt && b_ok) begin
            mem_addr  = b_addr;
            mem_wdata = b_wdata;
            mem_we    = b_we;
            mem_re    = !b_we;
        end
    end

    // Count cycles port B has been held off, saturating at the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_wait <= '0;
        end else if (!b_req || b_gnt) begin
            b_wait <= '0;
        end else if (b_wait != WAIT_MAX) begin
            b_wait <= b_wait + 4'd1;
        end
    end

    // One-cycle response pulses for reads and rejected accesses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rvalid <= 1'b0;
            a_err    <= 1'b0;
            a_rdata  <= '0;
            b_rvalid <= 1'b0;
            b_err    <= 1'b0;
            b_rdata  <= '0;
        end else begin
            a_rvalid <= a_gnt && (!a_ok || !a_we);
            a_err    <= a_gnt && !a_ok;
            a_rdata  <= a_rd ? mem_rdata : '0;
            b_rvalid <= b_gnt && (!b_ok || !b_we);
            b_err    <= b_gnt && !b_ok;
            b_rdata  <= b_rd ? mem_rdata : '0;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural memory.
// Inputs change 1 time unit after the rising edge.
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req, a_we, b_req, b_we;
    logic [15:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_gnt, a_rvalid, a_err;
    logic        b_gnt, b_rvalid, b_err;
    logic [15:0] a_rdata, b_rdata;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, mem_re;
    logic [15:0] mem [256];

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_re(mem_re), .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem_re ? mem[mem_addr[8:1]] : 16'h0000;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[8:1]] <= mem_wdata;
    end

    task automatic idle_inputs();
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        a_req = 1; a_we = 1; a_addr = 16'h0010; a_wdata = 16'hDEAD;
        next_cycle();
        next_cycle();
        n_checks++;
        if (a_gnt !== 1'b0 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_gnt: a_gnt=%b mem_we=%b required 0 0", a_gnt, mem_we);
        end
        n_checks++;
        if ({a_rvalid, a_err, a_rdata, b_rvalid, b_err, b_rdata} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_resp: a=%b%b%h b=%b%b%h required all zero",
                     a_rvalid, a_err, a_rdata, b_rvalid, b_err, b_rdata);
        end
        idle_inputs();
        rst_n = 1;
        next_cycle();
    endtask

    task automatic test_a_only();
        a_req = 1; a_we = 1; a_addr = 16'h0010; a_wdata = 16'hBEEF;
        #1;
        n_checks++;
        if (a_gnt !== 1 || mem_we !== 1 || mem_re !== 0
            || mem_addr !== 16'h0010 || mem_wdata !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL a_write_drive: gnt=%b we=%b re=%b addr=%h wd=%h required 1 1 0 0010 beef",
                     a_gnt, mem_we, mem_re, mem_addr, mem_wdata);
        end
        next_cycle();
        n_checks++;
        if (a_rvalid !== 0) begin
            n_fail++;
            $display("FAIL a_write_nopulse: a_rvalid=%b required 0", a_rvalid);
        end
        a_we = 0; a_wdata = 0;
        #1;
        n_checks++;
        if (a_gnt !== 1 || mem_re !== 1 || mem_we !== 0) begin
            n_fail++;
            $display("FAIL a_read_drive: gnt=%b re=%b we=%b required 1 1 0", a_gnt, mem_re, mem_we);
        end
        next_cycle();
        idle_inputs();
        n_checks++;
        if (a_rvalid !== 1 || a_err !== 0 || a_rdata !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL a_read_resp: rvalid=%b err=%b rdata=%h required 1 0 beef",
                     a_rvalid, a_err, a_rdata);
        end
        #1;
        n_checks++;
        if (mem_addr !== 0 || mem_wdata !== 0 || mem_we !== 0 || mem_re !== 0 || a_gnt !== 0) begin
            n_fail++;
            $display("FAIL idle_mem: addr=%h wd=%h we=%b re=%b gnt=%b required all zero",
                     mem_addr, mem_wdata, mem_we, mem_re, a_gnt);
        end
        next_cycle();
        n_checks++;
        if (a_rvalid !== 0 || a_rdata !== 0) begin
            n_fail++;
            $display("FAIL idle_resp: rvalid=%b rdata=%h required 0 0000", a_rvalid, a_rdata);
        end
    endtask

    task automatic test_priority();
        logic exp_b;
        a_req = 1; a_we = 1; a_addr = 16'h0020; a_wdata = 16'h5A5A;
        next_cycle();
        a_we = 0; a_wdata = 0;
        b_req = 1; b_we = 0; b_addr = 16'h0020;
        for (int i = 0; i < 10; i++) begin
            exp_b = (i == 4) || (i == 9);
            #1;
            n_checks++;
            if (a_gnt !== !exp_b || b_gnt !== exp_b) begin
                n_fail++;
                $display("FAIL prio_cycle%0d: a_gnt=%b b_gnt=%b required %b %b",
                         i, a_gnt, b_gnt, !exp_b, exp_b);
            end
            next_cycle();
            n_checks++;
            if (a_rvalid !== !exp_b || b_rvalid !== exp_b
                || (exp_b && b_rdata !== 16'h5A5A) || (!exp_b && a_rdata !== 16'h5A5A)) begin
                n_fail++;
                $display("FAIL prio_resp%0d: a_rv=%b a_rd=%h b_rv=%b b_rd=%h required b_rv=%b data 5a5a",
                         i, a_rvalid, a_rdata, b_rvalid, b_rdata, exp_b);
            end
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_misaligned();
        a_req = 1; a_we = 0; a_addr = 16'h0003;
        #1;
        n_checks++;
        if (a_gnt !== 1 || mem_we !== 0 || mem_re !== 0) begin
            n_fail++;
            $display("FAIL misaligned_drive: gnt=%b we=%b re=%b required 1 0 0", a_gnt, mem_we, mem_re);
        end
        next_cycle();
        idle_inputs();
        n_checks++;
        if (a_rvalid !== 1 || a_err !== 1 || a_rdata !== 0) begin
            n_fail++;
            $display("FAIL misaligned_resp: rvalid=%b err=%b rdata=%h required 1 1 0000",
                     a_rvalid, a_err, a_rdata);
        end
        next_cycle();
        n_checks++;
        if (a_rvalid !== 0 || a_err !== 0) begin
            n_fail++;
            $display("FAIL misaligned_pulse: rvalid=%b err=%b required 0 0", a_rvalid, a_err);
        end
    endtask

    task automatic test_out_of_range();
        a_req = 1; a_we = 1; a_addr = 16'h0000; a_wdata = 16'h1111;
        next_cycle();
        idle_inputs();
        b_req = 1; b_we = 1; b_addr = 16'h0200; b_wdata = 16'h1234;
        #1;
        n_checks++;
        if (b_gnt !== 1 || mem_we !== 0 || mem_re !== 0) begin
            n_fail++;
            $display("FAIL oor_drive: gnt=%b we=%b re=%b required 1 0 0", b_gnt, mem_we, mem_re);
        end
        next_cycle();
        idle_inputs();
        n_checks++;
        if (b_rvalid !== 1 || b_err !== 1 || b_rdata !== 0) begin
            n_fail++;
            $display("FAIL oor_resp: rvalid=%b err=%b rdata=%h required 1 1 0000",
                     b_rvalid, b_err, b_rdata);
        end
        a_req = 1; a_we = 0; a_addr = 16'h0000;
        next_cycle();
        idle_inputs();
        n_checks++;
        if (a_rvalid !== 1 || a_rdata !== 16'h1111) begin
            n_fail++;
            $display("FAIL oor_untouched: rvalid=%b rdata=%h required 1 1111", a_rvalid, a_rdata);
        end
    endtask

    task automatic test_back_to_back();
        b_req = 1; b_we = 1; b_addr = 16'h01FE; b_wdata = 16'h00AA;
        next_cycle();
        b_req = 0; b_we = 0; b_wdata = 0;
        a_req = 1; a_we = 0; a_addr = 16'h01FE;
        n_checks++;
        if (b_rvalid !== 0) begin
            n_fail++;
            $display("FAIL b2b_write_nopulse: b_rvalid=%b required 0", b_rvalid);
        end
        next_cycle();
        idle_inputs();
        n_checks++;
        if (a_rvalid !== 1 || a_rdata !== 16'h00AA) begin
            n_fail++;
            $display("FAIL b2b_read: rvalid=%b rdata=%h required 1 00aa", a_rvalid, a_rdata);
        end
    endtask

    task automatic test_drop();
        a_req = 1; a_we = 0; a_addr = 16'h0010;
        b_req = 1; b_we = 0; b_addr = 16'h0020;
        next_cycle();
        next_cycle();
        next_cycle();
        b_req = 0;
        next_cycle();
        n_checks++;
        if (b_rvalid !== 0) begin
            n_fail++;
            $display("FAIL drop_noresp: b_rvalid=%b required 0", b_rvalid);
        end
        b_req = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (b_gnt !== (i == 4)) begin
                n_fail++;
                $display("FAIL drop_cycle%0d: b_gnt=%b required %b", i, b_gnt, (i == 4));
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_reset_mid();
        a_req = 1; a_we = 0; a_addr = 16'h0010;
        b_req = 1; b_we = 0; b_addr = 16'h0020;
        next_cycle();
        next_cycle();
        n_checks++;
        if (a_rvalid !== 1 || a_rdata !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL rstmid_pre: rvalid=%b rdata=%h required 1 beef", a_rvalid, a_rdata);
        end
        rst_n = 0;
        #1;
        n_checks++;
        if (a_rvalid !== 0 || a_rdata !== 0 || a_gnt !== 0 || b_gnt !== 0 || mem_re !== 0) begin
            n_fail++;
            $display("FAIL rstmid_async: rvalid=%b rdata=%h a_gnt=%b b_gnt=%b re=%b required all zero",
                     a_rvalid, a_rdata, a_gnt, b_gnt, mem_re);
        end
        next_cycle();
        n_checks++;
        if (a_rvalid !== 0 || a_rdata !== 0) begin
            n_fail++;
            $display("FAIL rstmid_hold: rvalid=%b rdata=%h required 0 0000", a_rvalid, a_rdata);
        end
        rst_n = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (b_gnt !== (i == 4) || a_gnt !== (i != 4)) begin
                n_fail++;
                $display("FAIL rstmid_wait%0d: a_gnt=%b b_gnt=%b required %b %b",
                         i, a_gnt, b_gnt, (i != 4), (i == 4));
            end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
        n_checks++;
        if ({a_rvalid, a_err, a_rdata, b_rvalid, b_err, b_rdata} !== 36'h0 || mem_re !== 0) begin
            n_fail++;
            $display("FAIL rstmid_idle: a=%b%b%h b=%b%b%h re=%b required all zero",
                     a_rvalid, a_err, a_rdata, b_rvalid, b_err, b_rdata, mem_re);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        idle_inputs();
        rst_n = 0;
        test_reset();
        test_a_only();
        test_priority();
        test_misaligned();
        test_out_of_range();
        test_back_to_back();
        test_drop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Two-requester arbiter and sequencer in front of the 16-bit, 256-word single-cycle data memory. The CPU load/store path (port A) and a debug/DMA loader (port B) share the memory's single access port. The block grants at most one access per cycle and rejects misaligned or out-of-range addresses without touching the memory. It returns read data through a registered response stage. It sits between the processor datapath/loader and the data memory.

## Interface
- `ADDR_W`, 16, requester and memory address width (byte address).
- `DATA_W`, 16, data width.
- `MAX_WAIT`, 4, consecutive denied cycles after which port B gets priority over A (range 1..15).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `a_req` / `b_req`  in  1  access request; must be held with fields stable until granted.
- `a_we` / `b_we`  in  1  1 = write, 0 = read.
- `a_addr` / `b_addr`  in  ADDR_W  byte address.
- `a_wdata` / `b_wdata`  in  DATA_W  write data.
- `a_gnt` / `b_gnt`  out  1  combinational grant; the access completes in this cycle.
- `a_rvalid` / `b_rvalid`  out  1  registered one-cycle response pulse, for reads and for rejected accesses.
- `a_rdata` / `b_rdata`  out  DATA_W  registered read data; 0 unless a valid read response.
- `a_err` / `b_err`  out  1  registered; high with rvalid when the access was rejected.
- `mem_addr`  out  ADDR_W  to the memory address input.
- `mem_wdata`  out  DATA_W  to the memory write-data input.
- `mem_we`  out  1  to the memory write enable.
- `mem_re`  out  1  to the memory read enable.
- `mem_rdata`  in  DATA_W  combinational read data from the memory.

## Operation
- Priority: A wins by default. B wins when `b_wait == MAX_WAIT`. A lone requester always wins.
- `b_wait` is a 4-bit counter:
  - increments (saturating at `MAX_WAIT`) each cycle `b_req && !b_gnt`;
  - clears on `b_gnt` or `!b_req`.
- Validity check on the granted request:
  - `addr[0]` must be 0 (aligned word);
  - `addr[15:9]` must be 0 (within 256 words).
- Valid access: drive `mem_addr`/`mem_wdata` from the winner. Assert `mem_we` for a write, `mem_re` for a read.
- Invalid access:
  - the port is still granted (consumed);
  - `mem_we` and `mem_re` are forced 0;
  - next cycle `rvalid=1`, `err=1`, `rdata=0`.
- Valid write: no response pulse. The write is committed at the end of the grant cycle.
- Valid read: `mem_rdata` is captured at the end of the grant cycle. Next cycle `rvalid=1`, `err=0`, `rdata` = captured value.
- Idle cycle (no grant): all `mem_*` outputs are 0.

## Timing
- Reset values: `a_/b_rvalid`=0, `a_/b_rdata`=0, `a_/b_err`=0, `b_wait`=0. Combinational outputs follow inputs with the state at reset values.
- Grant and memory drive occur in the same cycle as `req`; read latency to `rvalid` is 1 cycle; throughput is 1 access/cycle total.
- Back-to-back accesses are legal. A write at cycle N followed by a read of the same address at N+1 returns the new data.
- Simultaneous A+B with `b_wait < MAX_WAIT`: A granted, B waits. At `b_wait == MAX_WAIT`: B granted, A waits one cycle.
- A `req` dropped before grant is legal. It produces no response and clears `b_wait` for B.
- Reset asserted mid-operation clears pending responses immediately (asynchronous). A response due in the next cycle is lost; no write is issued while `rst_n`=0 (grants are forced 0).

## Structure
- Package `dmem_arb_pkg`: `ADDR_W`/`DATA_W` defaults, `MEM_WORDS` (256), word-index bit range constants, and the aligned/in-range check expressed as a function.
- Sub-module `dmem_req_check`: combinational validity check, instantiated once per port. Everything else stays in the top level: priority, wait counter, and response registers.

## Test plan
- A only: write 0xBEEF to 0x0010, then read 0x0010 → `a_gnt`=1 both cycles; `a_rvalid`=1 with `a_rdata`=0xBEEF one cycle after the read; no pulse after the write.
- A and B both requesting continuously with `MAX_WAIT`=4 → A granted for 4 cycles, B granted on the 5th, then A again; `b_wait` returns to 0.
- A reads 0x0003 (misaligned) → `a_gnt`=1; `mem_we`=`mem_re`=0; next cycle `a_rvalid`=1, `a_err`=1, `a_rdata`=0.
- B writes 0x1234 to 0x0200 (out of range) → memory untouched (a read of 0x0000 still returns the prior value); `b_err` pulses.
- B writes 0x00AA to 0x01FE at cycle N, A reads 0x01FE at N+1 → `a_rdata`=0x00AA at N+2.
- A read granted, then `rst_n` pulled low before the next edge → `a_rvalid`=0 and `a_rdata`=0 during reset; after release all outputs are idle and `b_wait`=0.
